// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit saturating direction counters and EX-stage mispredict redirect.
// Optional `BRANCH_STATS_EN adds saturating resolve/mispredict counters (stat_branches, stat_mispredicts).
module branch_predict_ctrl #(
    parameter int IDX_BITS  = 3,
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_target,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic [WORD_SIZE-1:0] ex_pc,
    input  logic                 ex_pred_taken,
    input  logic [WORD_SIZE-1:0] ex_pred_target,
    input  logic                 ex_taken,
    input  logic [WORD_SIZE-1:0] ex_target,
    output logic                 redirect,
    output logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 flush_if_id,
    output logic                 flush_id_ex
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]          stat_branches,
    output logic [15:0]          stat_mispredicts
`endif
);

    localparam int TAG_BITS = WORD_SIZE - IDX_BITS;
    localparam int ENTRIES  = 2 ** IDX_BITS;
    localparam logic [WORD_SIZE-1:0] PC_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
    logic [TAG_BITS-1:0]  tag_d    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic [WORD_SIZE-1:0] target_d [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];
    logic [1:0]           ctr_d    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    logic                if_hit, ex_hit, resolve, mispredict;

    assign if_idx = if_pc[IDX_BITS-1:0];
    assign if_tag = if_pc[WORD_SIZE-1:IDX_BITS];
    assign ex_idx = ex_pc[IDX_BITS-1:0];
    assign ex_tag = ex_pc[WORD_SIZE-1:IDX_BITS];

    // Lookup reads registered state only, so a same-cycle update is seen next cycle.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = if_hit ? target_q[if_idx] : '0;

    assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign resolve    = ex_valid && ex_is_branch && !stall;
    assign mispredict = resolve && ((ex_taken != ex_pred_taken) ||
                                    (ex_taken && (ex_pred_target != ex_target)));

    assign redirect    = mispredict;
    assign flush_if_id = mispredict;
    assign flush_id_ex = mispredict;
    assign redirect_pc = !mispredict ? '0 : (ex_taken ? ex_target : ex_pc + PC_ONE);

    always_comb begin
        // NOTE: every _d starts as a copy of its _q so no path leaves it unassigned (no latches).
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (resolve) begin
            if (ex_hit) begin
                if (ex_taken) begin
                    if (ctr_q[ex_idx] != 2'd3) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
                    target_d[ex_idx] = ex_target;
                end else if (ctr_q[ex_idx] != 2'd0) begin
                    ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = ex_target;
                ctr_d[ex_idx]    = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!reset_n) begin
            // NOTE: the whole table is cleared, not only valid, so ctr/target read as zero after reset.
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_branches_q, stat_branches_d;
    logic [15:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (resolve && stat_branches_q != 16'hFFFF)       stat_branches_d    = stat_branches_q + 16'd1;
        if (mispredict && stat_mispredicts_q != 16'hFFFF) stat_mispredicts_d = stat_mispredicts_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: each row pushes its expected outputs when driven,
// and the row's task pops and compares them once the combinational outputs have settled.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] if_pc = '0;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic [15:0] ex_pc = '0;
    logic        ex_pred_taken = 1'b0;
    logic [15:0] ex_pred_target = '0;
    logic        ex_taken = 1'b0;
    logic [15:0] ex_target = '0;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    typedef struct packed {
        logic        pt;
        logic [15:0] ptg;
        logic        rd;
        logic [15:0] rpc;
        logic        fie;
        logic        fde;
    } out_t;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        stall;
        logic [15:0] if_pc;
        logic        v;
        logic        br;
        logic [15:0] pc;
        logic        ept;
        logic [15:0] eptg;
        logic        tk;
        logic [15:0] tgt;
        out_t        exp;
    } step_t;

    out_t  sb_q[$];
    string name_q[$];

    // Row constructor: flush outputs are expected to mirror redirect.
    function automatic step_t mk(string name, logic st, logic [15:0] ipc,
                                 logic v, logic br, logic [15:0] pc, logic ept, logic [15:0] eptg,
                                 logic tk, logic [15:0] tgt,
                                 logic pt, logic [15:0] ptg, logic rd, logic [15:0] rpc);
        step_t s;
        s.name = name; s.rst_n = 1'b1; s.stall = st; s.if_pc = ipc;
        s.v = v; s.br = br; s.pc = pc; s.ept = ept; s.eptg = eptg; s.tk = tk; s.tgt = tgt;
        s.exp = '{pt: pt, ptg: ptg, rd: rd, rpc: rpc, fie: rd, fde: rd};
        return s;
    endfunction

    task automatic drive(input step_t s);
        @(negedge clk);
        reset_n = s.rst_n; stall = s.stall; if_pc = s.if_pc;
        ex_valid = s.v; ex_is_branch = s.br; ex_pc = s.pc;
        ex_pred_taken = s.ept; ex_pred_target = s.eptg; ex_taken = s.tk; ex_target = s.tgt;
        sb_q.push_back(s.exp);
        name_q.push_back(s.name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0; stall = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        step_t tbl[$];
        out_t  exp, got;
        string nm;
        tbl.push_back(mk("reset_state", 0, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            if (i == 0) reset_n = 1'b0;
            #1;
            exp = sb_q.pop_front(); nm = name_q.pop_front();
            got = '{pred_taken, pred_target, redirect, redirect_pc, flush_if_id, flush_id_ex};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_alloc();
        step_t tbl[$];
        out_t  exp, got;
        string nm;
        tbl.push_back(mk("alloc_empty",    0, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("alloc_redirect", 0, 16'h0010, 1, 1, 16'h0010, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000, 1, 16'h0020));
        tbl.push_back(mk("alloc_hit",      0, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            exp = sb_q.pop_front(); nm = name_q.pop_front();
            got = '{pred_taken, pred_target, redirect, redirect_pc, flush_if_id, flush_id_ex};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
        end
    endtask

    // Entry at 0x0010 starts with ctr = 2, target 0x0020.
    task automatic test_counter();
        step_t tbl[$];
        out_t  exp, got;
        string nm;
        tbl.push_back(mk("ctr_tk1",      0, 16'h0010, 1, 1, 16'h0010, 1, 16'h0020, 1, 16'h0020, 1, 16'h0020, 0, 16'h0000));
        tbl.push_back(mk("ctr_tk2",      0, 16'h0010, 1, 1, 16'h0010, 1, 16'h0020, 1, 16'h0020, 1, 16'h0020, 0, 16'h0000));
        tbl.push_back(mk("ctr_nt_mis",   0, 16'h0010, 1, 1, 16'h0010, 1, 16'h0020, 0, 16'h0020, 1, 16'h0020, 1, 16'h0011));
        tbl.push_back(mk("ctr_at2",      0, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000));
        tbl.push_back(mk("ctr_nt_mis2",  0, 16'h0010, 1, 1, 16'h0010, 1, 16'h0020, 0, 16'h0020, 1, 16'h0020, 1, 16'h0011));
        tbl.push_back(mk("ctr_at1",      0, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0020, 0, 16'h0000));
        tbl.push_back(mk("ctr_nt_ok",    0, 16'h0010, 1, 1, 16'h0010, 0, 16'h0000, 0, 16'h0020, 0, 16'h0020, 0, 16'h0000));
        tbl.push_back(mk("ctr_nt_floor", 0, 16'h0010, 1, 1, 16'h0010, 0, 16'h0000, 0, 16'h0020, 0, 16'h0020, 0, 16'h0000));
        tbl.push_back(mk("ctr_tk_from0", 0, 16'h0010, 1, 1, 16'h0010, 0, 16'h0000, 1, 16'h0020, 0, 16'h0020, 1, 16'h0020));
        tbl.push_back(mk("ctr_at_one",   0, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0020, 0, 16'h0000));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            exp = sb_q.pop_front(); nm = name_q.pop_front();
            got = '{pred_taken, pred_target, redirect, redirect_pc, flush_if_id, flush_id_ex};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
        end
    endtask

    // Entry at 0x0010 has ctr = 1, target 0x0020.
    task automatic test_target();
        step_t tbl[$];
        out_t  exp, got;
        string nm;
        tbl.push_back(mk("tgt_change",   0, 16'h0010, 1, 1, 16'h0010, 1, 16'h0020, 1, 16'h0030, 0, 16'h0020, 1, 16'h0030));
        tbl.push_back(mk("tgt_updated",  0, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0030, 0, 16'h0000));
        tbl.push_back(mk("tgt_nt",       0, 16'h0010, 1, 1, 16'h0010, 1, 16'h0030, 0, 16'h0050, 1, 16'h0030, 1, 16'h0011));
        tbl.push_back(mk("tgt_nt_keeps", 0, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0030, 0, 16'h0000));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            exp = sb_q.pop_front(); nm = name_q.pop_front();
            got = '{pred_taken, pred_target, redirect, redirect_pc, flush_if_id, flush_id_ex};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
        end
    endtask

    task automatic test_alias();
        step_t tbl[$];
        out_t  exp, got;
        string nm;
        tbl.push_back(mk("alias_alloc",    0, 16'h0018, 1, 1, 16'h0018, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 1, 16'h0040));
        tbl.push_back(mk("alias_old_miss", 0, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("alias_new_hit",  0, 16'h0018, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000));
        tbl.push_back(mk("miss_nt",        0, 16'h0000, 1, 1, 16'h0025, 0, 16'h0000, 0, 16'h0060, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("miss_nt_noalloc",0, 16'h0025, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("non_branch",     0, 16'h0000, 1, 0, 16'h0033, 0, 16'h0000, 1, 16'h0070, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("non_branch_nop", 0, 16'h0033, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("bubble",         0, 16'h0000, 0, 1, 16'h0034, 0, 16'h0000, 1, 16'h0070, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("bubble_nop",     0, 16'h0034, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            exp = sb_q.pop_front(); nm = name_q.pop_front();
            got = '{pred_taken, pred_target, redirect, redirect_pc, flush_if_id, flush_id_ex};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
        end
    endtask

    // Entry at 0x0018 has ctr = 2, target 0x0040.
    task automatic test_stall();
        step_t tbl[$];
        out_t  exp, got;
        string nm;
        tbl.push_back(mk("stall_held1",  1, 16'h0018, 1, 1, 16'h0018, 1, 16'h0040, 0, 16'h0040, 1, 16'h0040, 0, 16'h0000));
        tbl.push_back(mk("stall_held2",  1, 16'h0018, 1, 1, 16'h0018, 1, 16'h0040, 0, 16'h0040, 1, 16'h0040, 0, 16'h0000));
        tbl.push_back(mk("stall_release",0, 16'h0018, 1, 1, 16'h0018, 1, 16'h0040, 0, 16'h0040, 1, 16'h0040, 1, 16'h0019));
        tbl.push_back(mk("stall_applied",0, 16'h0018, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0040, 0, 16'h0000));
        tbl.push_back(mk("wrap_pc",      0, 16'hFFFF, 1, 1, 16'hFFFF, 1, 16'h1234, 0, 16'h1234, 0, 16'h0000, 1, 16'h0000));
        tbl.push_back(mk("wrap_noalloc", 0, 16'hFFFF, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            exp = sb_q.pop_front(); nm = name_q.pop_front();
            got = '{pred_taken, pred_target, redirect, redirect_pc, flush_if_id, flush_id_ex};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t tbl[$];
        out_t  exp, got;
        string nm;
        tbl.push_back(mk("b2b_first",  0, 16'h0000, 1, 1, 16'h0101, 0, 16'h0000, 1, 16'h0200, 0, 16'h0000, 1, 16'h0200));
        tbl.push_back(mk("b2b_second", 0, 16'h0101, 1, 1, 16'h0102, 0, 16'h0000, 1, 16'h0300, 1, 16'h0200, 1, 16'h0300));
        tbl.push_back(mk("b2b_hit2",   0, 16'h0102, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0300, 0, 16'h0000));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            exp = sb_q.pop_front(); nm = name_q.pop_front();
            got = '{pred_taken, pred_target, redirect, redirect_pc, flush_if_id, flush_id_ex};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
        end
    endtask

    // Reset asserted while a taken mispredict at 0x0103 resolves: the update must be dropped.
    task automatic test_reset_mid_update();
        step_t tbl[$];
        out_t  exp, got;
        string nm;
        tbl.push_back(mk("rstmid_during", 0, 16'h0101, 1, 1, 16'h0103, 0, 16'h0000, 1, 16'h0400, 1, 16'h0200, 1, 16'h0400));
        tbl[0].rst_n = 1'b0;
        tbl.push_back(mk("rstmid_dropped", 0, 16'h0103, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("rstmid_cleared", 0, 16'h0101, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            exp = sb_q.pop_front(); nm = name_q.pop_front();
            got = '{pred_taken, pred_target, redirect, redirect_pc, flush_if_id, flush_id_ex};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
        end
    endtask

`ifdef BRANCH_STATS_EN
    // 5 resolved branches, 2 mispredicted; a stalled branch and a non-branch must not count.
    task automatic test_stats();
        step_t tbl[$];
        do_reset();
        tbl.push_back(mk("s1", 0, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000, 1, 16'h0210, 0, 16'h0000, 1, 16'h0210));
        tbl.push_back(mk("s2", 0, 16'h0000, 1, 1, 16'h0200, 1, 16'h0210, 1, 16'h0210, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("s_stall", 1, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000, 1, 16'h0210, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("s3", 0, 16'h0000, 1, 1, 16'h0200, 1, 16'h0210, 1, 16'h0210, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("s_nonbr", 0, 16'h0000, 1, 0, 16'h0200, 0, 16'h0000, 1, 16'h0210, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("s4", 0, 16'h0000, 1, 1, 16'h0200, 1, 16'h0210, 0, 16'h0210, 0, 16'h0000, 1, 16'h0201));
        tbl.push_back(mk("s5", 0, 16'h0000, 1, 1, 16'h0300, 0, 16'h0000, 0, 16'h0310, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk("s_idle", 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            void'(sb_q.pop_front());
            void'(name_q.pop_front());
        end
        checks++;
        if (stat_branches !== 16'd5) begin
            errors++;
            $display("FAIL stat_branches: got %0d expected 5", stat_branches);
        end
        checks++;
        if (stat_mispredicts !== 16'd2) begin
            errors++;
            $display("FAIL stat_mispredicts: got %0d expected 2", stat_mispredicts);
        end
        do_reset();
        #1;
        checks++;
        if (stat_branches !== 16'd0 || stat_mispredicts !== 16'd0) begin
            errors++;
            $display("FAIL stat_reset: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_target();
        test_alias();
        test_stall();
        test_back_to_back();
        test_reset_mid_update();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters for the 16-bit pipelined CPU.
- Supplies next-PC prediction to IF and resolves branches in EX against the actual branch outcome and target.
- On mispredict, generates the redirect PC and IF/ID, ID/EX flushes.
- Sits between the PC-select mux in IF and the EX-stage branch decision / target-adder logic; honours cache-miss stalls.

Parameters:
- IDX_BITS, 3, BTB index width; entry count = 2**IDX_BITS.
- WORD_SIZE, 16, PC and target width.
- TAG_BITS, WORD_SIZE-IDX_BITS, tag width, derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- stall  in  1  pipeline frozen (cache miss); blocks BTB update and stat counting
- if_pc  in  WORD_SIZE  PC being fetched
- pred_taken  out  1  BTB hit and counter MSB set
- pred_target  out  WORD_SIZE  predicted target, valid when pred_taken
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- ex_is_branch  in  1  EX instruction is BNE/BEQ/BGZ/BLZ
- ex_pc  in  WORD_SIZE  PC of EX instruction
- ex_pred_taken  in  1  prediction made for this instruction in IF, piped along
- ex_pred_target  in  WORD_SIZE  piped predicted target
- ex_taken  in  1  resolved branch outcome from EX decision logic
- ex_target  in  WORD_SIZE  computed branch target (PC+1+offset)
- redirect  out  1  mispredict; PC mux selects redirect_pc
- redirect_pc  out  WORD_SIZE  corrected PC
- flush_if_id  out  1  squash IF/ID at next edge
- flush_id_ex  out  1  squash ID/EX at next edge

Behaviour:
- Entry fields: valid, tag[TAG_BITS], target[WORD_SIZE], ctr[2]. Index = pc[IDX_BITS-1:0]; tag = pc[WORD_SIZE-1:IDX_BITS].
- Lookup is combinational, zero latency: hit = valid && tag match; pred_taken = hit && ctr[1]; pred_target = entry target when hit, else 0.
- resolve = ex_valid && ex_is_branch && !stall.
- Mispredict = resolve && (ex_taken != ex_pred_taken || (ex_taken && ex_pred_target != ex_target)).
- redirect, flush_if_id and flush_id_ex equal mispredict, combinational, same cycle as resolution.
- redirect_pc = ex_taken ? ex_target : ex_pc+1, wrapping mod 2**16. When redirect = 0, redirect_pc = 0.
- Update at the rising edge when resolve:
  - Hit, taken: ctr saturating increment (max 3); target <= ex_target.
  - Hit, not taken: ctr saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate entry (overwrite any occupant): valid = 1, tag, target = ex_target, ctr = 2 (weakly taken).
  - Miss, not taken: no allocation, no state change.
- Non-branch or bubble in EX: no update, no redirect.
- stall = 1: BTB unchanged, redirect/flush held 0. Resolution occurs on the first unstalled cycle; upstream holds EX inputs stable.
- Same-cycle lookup and update on the same index: lookup returns pre-update contents; the new value is visible next cycle.
- Reset (reset_n = 0 at an edge): all valid bits and ctr cleared to 0, targets and tags cleared to 0. All outputs are combinational from cleared state: pred_taken = 0, pred_target = 0. Flush and redirect outputs follow their inputs and are qualified by the bench holding ex_valid = 0.
- Reset mid-update: reset has priority; the pending update is discarded.

Optional Feature:
- BRANCH_STATS_EN
- Defined: adds outputs stat_branches[15:0] and stat_mispredicts[15:0].
  - stat_branches increments on each resolve; stat_mispredicts increments on each mispredict.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: neither port nor counter exists.

Test Plan:
1. After reset, if_pc = 16'h0010 -> pred_taken = 0, pred_target = 0. Resolve branch at ex_pc = 16'h0010, ex_taken = 1, ex_target = 16'h0020, ex_pred_taken = 0 -> redirect = 1, redirect_pc = 16'h0020, both flushes = 1. Next cycle if_pc = 16'h0010 -> pred_taken = 1, pred_target = 16'h0020.
2. Same entry (ctr = 2), resolved taken twice -> ctr = 3. Then not-taken resolve with ex_pred_taken = 1 -> redirect_pc = 16'h0011, ctr = 2, pred_taken still 1. Second not-taken -> ctr = 1, pred_taken = 0.
3. Target change: hit with ex_pred_target = 16'h0020, ex_taken = 1, ex_target = 16'h0030 -> redirect = 1, redirect_pc = 16'h0030; entry target updated to 16'h0030.
4. Aliasing: entry allocated at 16'h0010, then taken branch at 16'h0018 (same index, IDX_BITS = 3) -> entry overwritten; lookup of 16'h0010 misses (pred_taken = 0).
5. stall = 1 while mispredicting branch sits in EX -> redirect = 0, BTB unchanged. Drop stall -> redirect asserted that cycle, update applied at that edge. Wrap case: ex_pc = 16'hFFFF, not taken, ex_pred_taken = 1 -> redirect_pc = 16'h0000.
6. With BRANCH_STATS_EN: 5 branches resolved, 2 mispredicted -> stat_branches = 5, stat_mispredicts = 2. Assert reset_n = 0 for one edge -> both 0.
